// File: rtl/macu_ws_lane.sv
// macu_ws_lane: weight-stationary multi-lane MAC PE with shadow weights, sign mode and saturation
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   w_ld, wi        load wi (LANES x DW, signed) into the shadow weight bank
//   w_swap          copy shadow bank into active bank (old shadow if loaded the same edge)
//   in_vld          xi/ci/x_signed valid
//   xi              LANES x DW activations, signed or unsigned per x_signed
//   ci              upstream partial sum (signed, CW bits)
//   co, co_vld, ovf result, valid and overflow flag, two edges after capture
module macu_ws_lane #(
   parameter int DW    = 8,
   parameter int LANES = 4,
   parameter int CW    = 24,
   parameter int SAT   = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   w_ld,
   input  logic [LANES*DW-1:0]    wi,
   input  logic                   w_swap,
   input  logic                   in_vld,
   input  logic [LANES*DW-1:0]    xi,
   input  logic                   x_signed,
   input  logic signed [CW-1:0]   ci,
   output logic signed [CW-1:0]   co,
   output logic                   co_vld,
   output logic                   ovf
);
   localparam int PW = 2*DW+1;
   localparam int SW = PW + $clog2(LANES);
   logic [LANES*DW-1:0] w_sh, w_act, x1;
   logic xs1, vld1, vld2, fit;
   logic signed [CW-1:0] c1, c2, co_nx;
   logic signed [SW-1:0] sum, sum2;
   logic signed [PW-1:0] we, xe;
   logic signed [CW:0] s;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         w_sh  <= '0;
         w_act <= '0;
      end else begin
         if (w_ld) w_sh <= wi;
         if (w_swap) w_act <= w_sh;
      end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         vld1   <= 1'b0;
         x1     <= '0;
         xs1    <= 1'b0;
         c1     <= '0;
         vld2   <= 1'b0;
         sum2   <= '0;
         c2     <= '0;
         co_vld <= 1'b0;
         co     <= '0;
         ovf    <= 1'b0;
      end else begin
         vld1 <= in_vld;
         if (in_vld) begin
            x1  <= xi;
            xs1 <= x_signed;
            c1  <= ci;
         end
         vld2 <= vld1;
         if (vld1) begin
            sum2 <= sum;
            c2   <= c1;
         end
         co_vld <= vld2;
         if (vld2) begin
            co  <= co_nx;
            ovf <= !fit;
         end
      end
   // Activations get one extra bit so unsigned 255 and signed -1 share one signed multiplier.
   always_comb begin
      sum = '0;
      we  = '0;
      xe  = '0;
      for (int i = 0; i < LANES; i++) begin
         we  = PW'($signed(w_act[i*DW +: DW]));
         xe  = PW'($signed({xs1 & x1[i*DW+DW-1], x1[i*DW +: DW]}));
         sum = sum + SW'(we * xe);
      end
   end
   assign s     = (CW+1)'(sum2) + (CW+1)'(c2);
   assign fit   = s[CW] == s[CW-1];
   assign co_nx = (fit || SAT == 0) ? s[CW-1:0] :
                  s[CW] ? {1'b1, {(CW-1){1'b0}}} : {1'b0, {(CW-1){1'b1}}};
endmodule

// File: tb/tb_macu_ws_lane.sv
// tb_macu_ws_lane: directed self-checking bench for macu_ws_lane (SAT=1 and SAT=0 instances)
module tb_macu_ws_lane;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic w_ld = 1'b0, w_swap = 1'b0, in_vld = 1'b0, x_signed = 1'b0;
   logic [31:0] wi = '0, xi = '0;
   logic signed [23:0] ci = '0;
   logic signed [23:0] co, co_w;
   logic co_vld, ovf, co_vld_w, ovf_w;
   int n_cmp = 0, n_fail = 0;

   always #5 clk = ~clk;

   macu_ws_lane #(.DW(8), .LANES(4), .CW(24), .SAT(1)) dut (
      .clk(clk), .rst_n(rst_n), .w_ld(w_ld), .wi(wi), .w_swap(w_swap),
      .in_vld(in_vld), .xi(xi), .x_signed(x_signed), .ci(ci),
      .co(co), .co_vld(co_vld), .ovf(ovf));

   macu_ws_lane #(.DW(8), .LANES(4), .CW(24), .SAT(0)) dut_w (
      .clk(clk), .rst_n(rst_n), .w_ld(w_ld), .wi(wi), .w_swap(w_swap),
      .in_vld(in_vld), .xi(xi), .x_signed(x_signed), .ci(ci),
      .co(co_w), .co_vld(co_vld_w), .ovf(ovf_w));

   // load value v into all shadow lanes, then swap it into the active bank
   task automatic set_w(input logic [7:0] v);
      @(negedge clk); w_ld = 1'b1; wi = {4{v}};
      @(negedge clk); w_ld = 1'b0; w_swap = 1'b1;
      @(negedge clk); w_swap = 1'b0;
   endtask

   task automatic put(input logic v, input logic xs, input logic [31:0] x, input logic signed [23:0] c);
      in_vld = v; x_signed = xs; xi = x; ci = c;
   endtask

   task automatic test_reset;
      #2;
      n_cmp++; if (co !== 24'sd0) begin n_fail++; $display("FAIL reset_co got %0d want 0", co); end
      n_cmp++; if (co_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld got %b want 0", co_vld); end
      n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", ovf); end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_basic;
      set_w(8'd2);
      put(1'b1, 1'b1, {8'd4, 8'd3, 8'd2, 8'd1}, 24'sd100);
      @(negedge clk); put(1'b0, 1'b1, '0, '0);
      n_cmp++; if (co_vld !== 1'b0) begin n_fail++; $display("FAIL basic_vld_k got %b want 0", co_vld); end
      @(negedge clk);
      n_cmp++; if (co_vld !== 1'b0) begin n_fail++; $display("FAIL basic_vld_k1 got %b want 0", co_vld); end
      @(negedge clk);
      n_cmp++; if (co_vld !== 1'b1) begin n_fail++; $display("FAIL basic_vld_k2 got %b want 1", co_vld); end
      n_cmp++; if (co !== 24'sd120) begin n_fail++; $display("FAIL basic_co got %0d want 120", co); end
      n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL basic_ovf got %b want 0", ovf); end
      @(negedge clk);
      n_cmp++; if (co_vld !== 1'b0) begin n_fail++; $display("FAIL basic_vld_after got %b want 0", co_vld); end
      n_cmp++; if (co !== 24'sd120) begin n_fail++; $display("FAIL basic_hold got %0d want 120", co); end
   endtask

   task automatic test_sign;
      set_w(8'd1);
      put(1'b1, 1'b1, 32'hFFFF_FFFF, 24'sd0);
      @(negedge clk); put(1'b1, 1'b0, 32'hFFFF_FFFF, 24'sd0);
      @(negedge clk); put(1'b0, 1'b0, '0, '0);
      @(negedge clk);
      n_cmp++; if (co !== -24'sd4 || co_vld !== 1'b1) begin n_fail++; $display("FAIL sign_signed got %0d vld %b want -4 vld 1", co, co_vld); end
      @(negedge clk);
      n_cmp++; if (co !== 24'sd1020 || co_vld !== 1'b1) begin n_fail++; $display("FAIL sign_unsigned got %0d vld %b want 1020 vld 1", co, co_vld); end
   endtask

   task automatic test_extreme;
      set_w(8'h80);
      put(1'b1, 1'b1, 32'h8080_8080, 24'sd0);
      @(negedge clk); put(1'b0, 1'b0, '0, '0);
      @(negedge clk); @(negedge clk);
      n_cmp++; if (co !== 24'sd65536) begin n_fail++; $display("FAIL extreme_co got %0d want 65536", co); end
      n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL extreme_ovf got %b want 0", ovf); end
   endtask

   task automatic test_saturation;
      set_w(8'd2);
      put(1'b1, 1'b1, {8'd4, 8'd3, 8'd2, 8'd1}, 24'sd8388600);
      @(negedge clk); put(1'b0, 1'b0, '0, '0);
      @(negedge clk); @(negedge clk);
      n_cmp++; if (co !== 24'sd8388607 || ovf !== 1'b1) begin n_fail++; $display("FAIL sat_pos got %0d ovf %b want 8388607 ovf 1", co, ovf); end
      n_cmp++; if (co_w !== -24'sd8388596 || ovf_w !== 1'b1) begin n_fail++; $display("FAIL wrap_pos got %0d ovf %b want -8388596 ovf 1", co_w, ovf_w); end
      set_w(8'd1);
      put(1'b1, 1'b1, 32'hFFFF_FFFF, -24'sd8388608);
      @(negedge clk); put(1'b0, 1'b0, '0, '0);
      @(negedge clk); @(negedge clk);
      n_cmp++; if (co !== -24'sd8388608 || ovf !== 1'b1) begin n_fail++; $display("FAIL sat_neg got %0d ovf %b want -8388608 ovf 1", co, ovf); end
      n_cmp++; if (co_w !== 24'sd8388604 || ovf_w !== 1'b1) begin n_fail++; $display("FAIL wrap_neg got %0d ovf %b want 8388604 ovf 1", co_w, ovf_w); end
   endtask

   // active=1, shadow=3; swap with input 3, load 5 + swap with input 5 (active gets old shadow 3),
   // swap again with input 6 so it sees 5
   task automatic test_back_to_back;
      int exp_co [6] = '{4, 4, 12, 12, 12, 20};
      set_w(8'd1);
      @(negedge clk); w_ld = 1'b1; wi = {4{8'd3}};
      for (int j = 0; j < 9; j++) begin
         @(negedge clk);
         if (j >= 3) begin
            n_cmp++;
            if (co !== 24'(exp_co[j-3]) || co_vld !== 1'b1)
               begin n_fail++; $display("FAIL swap_out%0d got %0d vld %b want %0d vld 1", j-3, co, co_vld, exp_co[j-3]); end
         end
         w_ld = (j == 4); wi = {4{8'd5}};
         w_swap = (j == 2 || j == 4 || j == 5);
         if (j < 6) put(1'b1, 1'b1, 32'h0101_0101, 24'sd0);
         else put(1'b0, 1'b0, '0, '0);
      end
   endtask

   task automatic test_reset_mid;
      put(1'b1, 1'b1, 32'h0101_0101, 24'sd7);
      @(negedge clk); put(1'b1, 1'b1, 32'h0101_0101, 24'sd9);
      @(negedge clk); put(1'b0, 1'b0, '0, '0); rst_n = 1'b0;
      #1;
      n_cmp++; if (co !== 24'sd0 || co_vld !== 1'b0 || ovf !== 1'b0) begin n_fail++; $display("FAIL rstmid_now got co %0d vld %b ovf %b want 0 0 0", co, co_vld, ovf); end
      @(negedge clk); rst_n = 1'b1;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         n_cmp++; if (co_vld !== 1'b0) begin n_fail++; $display("FAIL rstmid_ghost%0d got vld %b want 0", j, co_vld); end
      end
      w_swap = 1'b1;
      @(negedge clk); w_swap = 1'b0; put(1'b1, 1'b1, 32'h0101_0101, 24'sd77);
      @(negedge clk); put(1'b0, 1'b0, '0, '0);
      @(negedge clk); @(negedge clk);
      n_cmp++; if (co !== 24'sd77 || co_vld !== 1'b1) begin n_fail++; $display("FAIL rstmid_zero_w got %0d vld %b want 77 vld 1", co, co_vld); end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_sign;
      test_extreme;
      test_saturation;
      test_back_to_back;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
